// File: rtl/byte_serial_adder_pkg.sv
// Shared constants and state encoding for the byte-serial adder.
package byte_serial_adder_pkg;

    localparam int BYTE_W     = 8;
    localparam int DEF_NBYTES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/carryselectadder8bit.sv
// 8-bit carry-select adder: low nibble ripples, high nibble is precomputed
// for both carry-in values and selected by the low nibble's carry.
module carryselectadder8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [4:0] lo;
    logic [4:0] hi0;
    logic [4:0] hi1;

    assign lo  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, cin};
    assign hi0 = {1'b0, a[7:4]} + {1'b0, b[7:4]};
    assign hi1 = {1'b0, a[7:4]} + {1'b0, b[7:4]} + 5'd1;

    assign sum  = {(lo[4] ? hi1[3:0] : hi0[3:0]), lo[3:0]};
    assign cout = lo[4] ? hi1[4] : hi0[4];

endmodule

// File: rtl/byte_serial_adder.sv
// Wide adder that feeds one shared 8-bit adder stage a byte per clock, LSB first,
// with valid/ready handshakes on the operand and result sides.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | one byte slice added per cycle through the shared stage
// DONE  | result held with out_valid=1 until out_ready
module byte_serial_adder
    import byte_serial_adder_pkg::*;
#(
    parameter int NBYTES = DEF_NBYTES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BYTE_W*NBYTES-1:0] A,
    input  logic [BYTE_W*NBYTES-1:0] B,
    input  logic                     Cin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BYTE_W*NBYTES-1:0] Sum,
    output logic                     Cout,
    output logic                     Ovf
);

    localparam int W  = BYTE_W * NBYTES;
    localparam int CW = $clog2(NBYTES);
    localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

    state_t          state_q;
    state_t          state_d;
    logic [W-1:0]    op_a;
    logic [W-1:0]    op_b;
    logic            carry_q;
    logic [CW-1:0]   cnt_q;
    logic            a_msb;
    logic            b_msb;
    logic [BYTE_W-1:0] stage_sum;
    logic            stage_cout;

    carryselectadder8bit u_stage (
        .a    (op_a[BYTE_W-1:0]),
        .b    (op_b[BYTE_W-1:0]),
        .cin  (carry_q),
        .sum  (stage_sum),
        .cout (stage_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (cnt_q == LAST) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);

    // Sum doubles as the result shift register; it is only qualified by out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a    <= '0;
            op_b    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
            Sum     <= '0;
            Cout    <= 1'b0;
            Ovf     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_a    <= A;
                        op_b    <= B;
                        carry_q <= Cin;
                        cnt_q   <= '0;
                        a_msb   <= A[W-1];
                        b_msb   <= B[W-1];
                    end
                end
                RUN: begin
                    Sum     <= {stage_sum, Sum[W-1:BYTE_W]};
                    op_a    <= op_a >> BYTE_W;
                    op_b    <= op_b >> BYTE_W;
                    carry_q <= stage_cout;
                    if (cnt_q == LAST) begin
                        Cout <= stage_cout;
                        Ovf  <= (a_msb == b_msb) && (stage_sum[BYTE_W-1] != a_msb);
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_serial_adder.sv
// Randomized and directed checks of byte_serial_adder against an arithmetic
// reference, on a 4-byte and a 2-byte instance.
module tb_byte_serial_adder;

    logic        clk = 1'b0;
    logic        rst;

    logic        iv4, ir4, cin4, ov4, ordy4, co4, of4;
    logic [31:0] a4, b4, s4;

    logic        iv2, ir2, cin2, ov2, ordy2, co2, of2;
    logic [15:0] a2, b2, s2;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    byte_serial_adder #(.NBYTES(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .A(a4), .B(b4), .Cin(cin4),
        .out_valid(ov4), .out_ready(ordy4), .Sum(s4), .Cout(co4), .Ovf(of4)
    );

    byte_serial_adder #(.NBYTES(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .A(a2), .B(b2), .Cin(cin2),
        .out_valid(ov2), .out_ready(ordy2), .Sum(s2), .Cout(co2), .Ovf(of2)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic run4(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input int hold);
        logic [32:0] ref_full;
        logic        ref_ovf;
        int          lat;
        ref_full = {1'b0, a} + {1'b0, b} + {32'b0, cin};
        ref_ovf  = (a[31] == b[31]) && (ref_full[31] != a[31]);
        @(posedge clk); #1;
        chk("in_ready_idle", ir4, 1);
        a4 = a; b4 = b; cin4 = cin; iv4 = 1'b1;
        @(posedge clk); #1;
        iv4 = 1'b0; a4 = $urandom; b4 = $urandom; cin4 = 1'($urandom);
        lat = 0;
        while (!ov4 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency4", lat, 4);
        for (int i = 0; i < hold; i++) begin
            iv4 = 1'($urandom); a4 = $urandom; b4 = $urandom;
            @(posedge clk); #1;
            chk("hold_sum", s4, ref_full[31:0]);
            chk("hold_in_ready", ir4, 0);
            chk("hold_out_valid", ov4, 1);
        end
        iv4 = 1'b0;
        chk("sum4", s4, ref_full[31:0]);
        chk("cout4", co4, ref_full[32]);
        chk("ovf4", of4, ref_ovf);
        ordy4 = 1'b1;
        @(posedge clk); #1;
        ordy4 = 1'b0;
        chk("out_valid_drop", ov4, 0);
        chk("in_ready_back", ir4, 1);
        chk("sum_kept", s4, ref_full[31:0]);
    endtask

    task automatic run2(input logic [15:0] a, input logic [15:0] b, input logic cin);
        logic [16:0] ref_full;
        int          lat;
        ref_full = {1'b0, a} + {1'b0, b} + {16'b0, cin};
        @(posedge clk); #1;
        a2 = a; b2 = b; cin2 = cin; iv2 = 1'b1;
        @(posedge clk); #1;
        iv2 = 1'b0; a2 = 16'($urandom);
        lat = 0;
        while (!ov2 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency2", lat, 2);
        chk("sum2", s2, ref_full[15:0]);
        chk("cout2", co2, ref_full[16]);
        chk("ovf2", of2, (a[15] == b[15]) && (ref_full[15] != a[15]));
        ordy2 = 1'b1;
        @(posedge clk); #1;
        ordy2 = 1'b0;
        chk("in_ready2", ir2, 1);
    endtask

    initial begin
        rst = 1'b1;
        iv4 = 0; a4 = 0; b4 = 0; cin4 = 0; ordy4 = 0;
        iv2 = 0; a2 = 0; b2 = 0; cin2 = 0; ordy2 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", ir4, 1);
        chk("rst_out_valid", ov4, 0);
        chk("rst_sum", s4, 0);
        chk("rst_cout", co4, 0);
        chk("rst_ovf", of4, 0);
        rst = 1'b0;

        run4(32'hFFFFFFFF, 32'h00000001, 1'b0, 0);
        run4(32'h12345678, 32'h0000FFFF, 1'b1, 0);
        run4(32'h7FFFFFFF, 32'h00000001, 1'b0, 0);
        run4(32'h00000010, 32'h00000020, 1'b0, 10);

        // reset two cycles into RUN must abort without exposing a result
        @(posedge clk); #1;
        a4 = 32'hDEADBEEF; b4 = 32'h11111111; iv4 = 1'b1;
        @(posedge clk); #1;
        iv4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_out_valid", ov4, 0);
        chk("abort_sum", s4, 0);
        chk("abort_cout", co4, 0);
        chk("abort_in_ready", ir4, 1);
        run4(32'h01010101, 32'h01010101, 1'b0, 0);

        run2(16'hFF80, 16'h0080, 1'b0);
        run2(16'h7FFF, 16'h0001, 1'b0);

        for (int k = 0; k < 20; k++)
            run4($urandom, $urandom, 1'($urandom), int'($urandom_range(0, 3)));
        for (int k = 0; k < 10; k++)
            run2(16'($urandom), 16'($urandom), 1'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
